// File: rtl/raster_addr_gen_if.sv
// Beat stream carrying one scan coordinate and its linear buffer address.
// The producer drives everything except out_ready.
interface raster_addr_gen_if #(
   parameter int MAX_WIDTH  = 32,
   parameter int MAX_HEIGHT = 32
);
   localparam int CW = $clog2(MAX_WIDTH);
   localparam int RW = $clog2(MAX_HEIGHT);
   localparam int AW = $clog2(MAX_WIDTH * MAX_HEIGHT);

   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] column;
   logic [RW-1:0] row;
   logic [AW-1:0] addr;
   logic          last_inner;
   logic          last;

   modport master (
      output out_valid, column, row, addr, last_inner, last,
      input  out_ready
   );

   modport slave (
      input  out_valid, column, row, addr, last_inner, last,
      output out_ready
   );
endinterface

// File: rtl/raster_addr_gen.sv
// 2-D raster scan generator: issues (column, row, addr) beats over a latched
// rectangle in row- or column-major order under valid/ready back-pressure.
//
//   state  | meaning
//   IDLE   | waiting for start; config latched on start
//   RUN    | presenting beats; advance on out_valid & out_ready
//   DONE   | one-cycle done pulse, then back to IDLE
module raster_addr_gen #(
   parameter int MAX_WIDTH  = 32,
   parameter int MAX_HEIGHT = 32,
   localparam int CW = $clog2(MAX_WIDTH),
   localparam int RW = $clog2(MAX_HEIGHT),
   localparam int AW = $clog2(MAX_WIDTH * MAX_HEIGHT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [CW:0]          cfg_width_i,
   input  logic [RW:0]          cfg_height_i,
   input  logic                 cfg_col_major_i,
   raster_addr_gen_if.master    beat,
   output logic                 busy_o,
   output logic                 done_o
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CW:0]   W_MAX = (CW+1)'(MAX_WIDTH);
   localparam logic [RW:0]   H_MAX = (RW+1)'(MAX_HEIGHT);
   localparam logic [CW:0]   ONE_W = (CW+1)'(1);
   localparam logic [RW:0]   ONE_H = (RW+1)'(1);
   localparam logic [AW-1:0] PITCH = AW'(MAX_WIDTH);

   state_t        state_q, state_d;
   logic [CW:0]   w_q, w_d;
   logic [RW:0]   h_q, h_d;
   logic          cm_q, cm_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] addr_q, addr_d;

   logic [CW:0]   w_clamp;
   logic [RW:0]   h_clamp;
   logic          col_last, row_last, inner_last, outer_last, xfer;

   assign w_clamp    = (cfg_width_i  > W_MAX) ? W_MAX : cfg_width_i;
   assign h_clamp    = (cfg_height_i > H_MAX) ? H_MAX : cfg_height_i;
   assign col_last   = ({1'b0, col_q} == (w_q - ONE_W));
   assign row_last   = ({1'b0, row_q} == (h_q - ONE_H));
   assign inner_last = cm_q ? row_last : col_last;
   assign outer_last = cm_q ? col_last : row_last;
   assign xfer       = (state_q == S_RUN) && beat.out_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) begin
            if ((w_clamp == '0) || (h_clamp == '0)) state_d = S_DONE;
            else                                    state_d = S_RUN;
         end
         S_RUN:   if (xfer && inner_last && outer_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      beat.out_valid  = (state_q == S_RUN);
      beat.last_inner = (state_q == S_RUN) && inner_last;
      beat.last       = (state_q == S_RUN) && inner_last && outer_last;
      busy_o          = (state_q != S_IDLE);
      done_o          = (state_q == S_DONE);
   end

   // Counters hold on the final beat so the last coordinate stays visible.
   always_comb begin
      w_d   = w_q;
      h_d   = h_q;
      cm_d  = cm_q;
      col_d = col_q;
      row_d = row_q;
      if ((state_q == S_IDLE) && start_i) begin
         w_d   = w_clamp;
         h_d   = h_clamp;
         cm_d  = cfg_col_major_i;
         col_d = '0;
         row_d = '0;
      end else if (xfer && !(inner_last && outer_last)) begin
         if (!cm_q) begin
            if (col_last) begin
               col_d = '0;
               row_d = row_q + RW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end else begin
            if (row_last) begin
               row_d = '0;
               col_d = col_q + CW'(1);
            end else begin
               row_d = row_q + RW'(1);
            end
         end
      end
      // Pitch is the fixed buffer stride, independent of the scan width.
      addr_d = AW'(row_d) * PITCH + AW'(col_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q    <= '0;
         h_q    <= '0;
         cm_q   <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else begin
         w_q    <= w_d;
         h_q    <= h_d;
         cm_q   <= cm_d;
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end

   assign beat.column = col_q;
   assign beat.row    = row_q;
   assign beat.addr   = addr_q;
endmodule

// File: tb/tb_raster_addr_gen.sv
// Directed bench for raster_addr_gen: scan order, addresses, flags,
// back-pressure, clamping, zero-size scans, reset abort and start-while-busy.
module tb_raster_addr_gen;
   localparam int MW = 32;
   localparam int MH = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic [5:0] cfg_width_i;
   logic [5:0] cfg_height_i;
   logic       cfg_col_major_i;
   logic       busy_o;
   logic       done_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   raster_addr_gen_if #(.MAX_WIDTH(MW), .MAX_HEIGHT(MH)) beat ();

   raster_addr_gen #(.MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .cfg_width_i     (cfg_width_i),
      .cfg_height_i    (cfg_height_i),
      .cfg_col_major_i (cfg_col_major_i),
      .beat            (beat),
      .busy_o          (busy_o),
      .done_o          (done_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int w, input int h, input bit cm);
      start_i         = 1'b1;
      cfg_width_i     = 6'(w);
      cfg_height_i    = 6'(h);
      cfg_col_major_i = cm;
      tick();
      start_i         = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(beat.out_valid), 0);
      check({tag, "_col"},   32'(beat.column), 0);
      check({tag, "_row"},   32'(beat.row), 0);
      check({tag, "_addr"},  32'(beat.addr), 0);
      check({tag, "_li"},    32'(beat.last_inner), 0);
      check({tag, "_last"},  32'(beat.last), 0);
      check({tag, "_busy"},  32'(busy_o), 0);
      check({tag, "_done"},  32'(done_o), 0);
   endtask

   // Streams w x h beats (effective dims) and checks each against an index model.
   task automatic stream(input int w, input int h, input bit cm, input bit stall,
                         input int stop_after, input bit inject);
      int  k, cyc, dones, total, limit, ec, er, want;
      bit  rdy;
      k = 0; cyc = 0; dones = 0;
      total = w * h;
      limit = 4 * total + 20;
      want  = (stop_after < total) ? stop_after : total;
      while (k < want && cyc < limit) begin
         rdy = stall ? (cyc % 3 == 0) : 1'b1;
         beat.out_ready = rdy;
         if (inject && k == 5) begin
            start_i      = 1'b1;
            cfg_width_i  = 6'd2;
            cfg_height_i = 6'd2;
         end else begin
            start_i = 1'b0;
         end
         ec = cm ? k / h : k % w;
         er = cm ? k % h : k / w;
         check("valid", 32'(beat.out_valid), 1);
         check("col",   32'(beat.column), 32'(ec));
         check("row",   32'(beat.row), 32'(er));
         check("addr",  32'(beat.addr), 32'(er * MW + ec));
         if (rdy) begin
            check("last_inner", 32'(beat.last_inner), cm ? 32'(er == h - 1) : 32'(ec == w - 1));
            check("last", 32'(beat.last), 32'(k == total - 1));
            k++;
         end
         if (done_o) dones++;
         tick();
         cyc++;
      end
      start_i = 1'b0;
      check("beats", 32'(k), 32'(want));
      check("early_done", 32'(dones), 0);
      if (stop_after >= total) begin
         check("done_pulse", 32'(done_o), 1);
         check("done_valid", 32'(beat.out_valid), 0);
         check("done_busy",  32'(busy_o), 1);
         tick();
         check("done_clear", 32'(done_o), 0);
         check("idle_busy",  32'(busy_o), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      start_i         = 1'b0;
      cfg_width_i     = '0;
      cfg_height_i    = '0;
      cfg_col_major_i = 1'b0;
      beat.out_ready  = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check_all_zero("reset");

      do_start(4, 3, 1'b0);
      stream(4, 3, 1'b0, 1'b0, 1000, 1'b0);

      do_start(4, 3, 1'b1);
      stream(4, 3, 1'b1, 1'b0, 1000, 1'b0);

      do_start(3, 2, 1'b0);
      stream(3, 2, 1'b0, 1'b1, 1000, 1'b0);

      do_start(0, 5, 1'b0);
      check("zero_valid", 32'(beat.out_valid), 0);
      check("zero_done",  32'(done_o), 1);
      check("zero_busy",  32'(busy_o), 1);
      tick();
      check("zero_done_clr", 32'(done_o), 0);
      check("zero_idle",     32'(busy_o), 0);
      check("zero_valid2",   32'(beat.out_valid), 0);

      do_start(40, 1, 1'b0);
      stream(32, 1, 1'b0, 1'b0, 1000, 1'b0);

      do_start(8, 8, 1'b0);
      stream(8, 8, 1'b0, 1'b0, 10, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("abort");
      for (int i = 0; i < 3; i++) begin
         check("abort_no_done", 32'(done_o), 0);
         tick();
      end
      do_start(2, 2, 1'b0);
      stream(2, 2, 1'b0, 1'b0, 1000, 1'b0);

      do_start(4, 4, 1'b0);
      stream(4, 4, 1'b0, 1'b0, 1000, 1'b1);

      do_start(1, 1, 1'b0);
      stream(1, 1, 1'b0, 1'b0, 1000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
